// File: rtl/round_judge.sv
// Round resolution and scoring for the N-choice animal duel (cyclic dominance, saturating scores).
// Latency: done pulses 3 cycles after the start edge; results at +2, scores/gameOver at +3.
// Backpressure: none; start is accepted only in IDLE and ignored otherwise (no queuing).
module round_judge #(
  parameter int NUM_CHOICES    = 3,
  parameter int SCORE_W        = 4,
  parameter int WIN_SCORE      = 9,
  parameter int DEFAULT_CHOICE = 0,
  localparam int IDX_W = $clog2(NUM_CHOICES),
  localparam int SCN_W = $clog2(NUM_CHOICES * NUM_CHOICES)
) (
  input  logic                   clk,
  input  logic                   stateReset,
  input  logic                   start,
  input  logic                   newGame,
  input  logic [NUM_CHOICES-1:0] p1Choice,
  input  logic [NUM_CHOICES-1:0] p2Choice,
  output logic                   busy,
  output logic                   done,
  output logic [SCN_W-1:0]       scenario,
  output logic                   winner1,
  output logic                   winner2,
  output logic                   tie,
  output logic                   invalid1,
  output logic                   invalid2,
  output logic [SCORE_W-1:0]     player1,
  output logic [SCORE_W-1:0]     player2,
  output logic                   gameOver
);

  // A choice d steps "ahead" of the opponent wins when d is in the lower half of the cycle.
  localparam int HALF = (NUM_CHOICES - 1) / 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_JUDGE,
    S_SCORE,
    S_GAMEOVER
  } state_t;

  state_t                 state_q;
  logic [NUM_CHOICES-1:0] p1_raw_q, p2_raw_q;
  logic [IDX_W-1:0]       p1_idx_q, p2_idx_q;
  logic                   busy_q, done_q;
  logic [SCN_W-1:0]       scn_q;
  logic                   w1_q, w2_q, tie_q;
  logic                   inv1_q, inv2_q;
  logic [SCORE_W-1:0]     s1_q, s2_q;
  logic                   go_q;

  logic                   p1_ok_d, p2_ok_d;
  logic [IDX_W-1:0]       p1_idx_d, p2_idx_d;
  logic [IDX_W:0]         diff_d;
  logic                   tie_d, w1_d, w2_d;
  logic [SCN_W-1:0]       scn_d;
  logic [SCORE_W-1:0]     s1_d, s2_d;
  logic                   end_d;

  // Position of the set bit; only meaningful when the vector is one-hot.
  function automatic logic [IDX_W-1:0] oh_index(input logic [NUM_CHOICES-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_CHOICES; i++) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // Decode, judge and next-score arithmetic feeding the FSM stages.
  always_comb begin
    p1_ok_d  = $onehot(p1_raw_q);
    p2_ok_d  = $onehot(p2_raw_q);
    p1_idx_d = p1_ok_d ? oh_index(p1_raw_q) : IDX_W'(DEFAULT_CHOICE);
    p2_idx_d = p2_ok_d ? oh_index(p2_raw_q) : IDX_W'(DEFAULT_CHOICE);

    // (p2 - p1) mod N without a divider: both indices are already < N.
    if (p2_idx_q >= p1_idx_q) begin
      diff_d = {1'b0, p2_idx_q} - {1'b0, p1_idx_q};
    end else begin
      diff_d = {1'b0, p2_idx_q} + (IDX_W+1)'(NUM_CHOICES) - {1'b0, p1_idx_q};
    end
    tie_d = (diff_d == '0);
    w1_d  = !tie_d && (diff_d <= (IDX_W+1)'(HALF));
    w2_d  = !tie_d && !w1_d;
    scn_d = SCN_W'(p1_idx_q) * SCN_W'(NUM_CHOICES) + SCN_W'(p2_idx_q);

    s1_d = s1_q;
    s2_d = s2_q;
    if (w1_q && (s1_q < SCORE_W'(WIN_SCORE))) s1_d = s1_q + SCORE_W'(1);
    if (w2_q && (s2_q < SCORE_W'(WIN_SCORE))) s2_d = s2_q + SCORE_W'(1);
    end_d = (s1_d == SCORE_W'(WIN_SCORE)) || (s2_d == SCORE_W'(WIN_SCORE));
  end

  // Round sequencer: capture, decode, judge, score, with registered outputs.
  always_ff @(posedge clk or posedge stateReset) begin
    if (stateReset) begin
      state_q  <= S_IDLE;
      p1_raw_q <= '0;
      p2_raw_q <= '0;
      p1_idx_q <= '0;
      p2_idx_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      scn_q    <= '0;
      w1_q     <= 1'b0;
      w2_q     <= 1'b0;
      tie_q    <= 1'b0;
      inv1_q   <= 1'b0;
      inv2_q   <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
      go_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (newGame) begin
            s1_q   <= '0;
            s2_q   <= '0;
            scn_q  <= '0;
            w1_q   <= 1'b0;
            w2_q   <= 1'b0;
            tie_q  <= 1'b0;
            inv1_q <= 1'b0;
            inv2_q <= 1'b0;
          end else if (start) begin
            p1_raw_q <= p1Choice;
            p2_raw_q <= p2Choice;
            busy_q   <= 1'b1;
            state_q  <= S_DECODE;
          end
        end
        S_DECODE: begin
          p1_idx_q <= p1_idx_d;
          p2_idx_q <= p2_idx_d;
          inv1_q   <= !p1_ok_d;
          inv2_q   <= !p2_ok_d;
          state_q  <= S_JUDGE;
        end
        S_JUDGE: begin
          w1_q    <= w1_d;
          w2_q    <= w2_d;
          tie_q   <= tie_d;
          scn_q   <= scn_d;
          state_q <= S_SCORE;
        end
        S_SCORE: begin
          s1_q    <= s1_d;
          s2_q    <= s2_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          go_q    <= end_d;
          state_q <= end_d ? S_GAMEOVER : S_IDLE;
        end
        S_GAMEOVER: begin
          if (newGame) begin
            s1_q    <= '0;
            s2_q    <= '0;
            scn_q   <= '0;
            w1_q    <= 1'b0;
            w2_q    <= 1'b0;
            tie_q   <= 1'b0;
            inv1_q  <= 1'b0;
            inv2_q  <= 1'b0;
            go_q    <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign scenario = scn_q;
  assign winner1  = w1_q;
  assign winner2  = w2_q;
  assign tie      = tie_q;
  assign invalid1 = inv1_q;
  assign invalid2 = inv2_q;
  assign player1  = s1_q;
  assign player2  = s2_q;
  assign gameOver = go_q;

endmodule

// File: tb/tb_round_judge.sv
// Bench for round_judge: instance 0 is N=3 with WIN_SCORE=2, instance 1 is N=5 with WIN_SCORE=9.
// A round-level model predicts every output each cycle; directed rounds add literal expectations.
// Inputs change on the falling edge, outputs are compared on the falling edge.
module tb_round_judge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       st_a = 1'b0, ng_a = 1'b0;
  logic [2:0] p1_a = '0, p2_a = '0;
  logic       busy_a, done_a, w1_a, w2_a, tie_a, i1_a, i2_a, go_a;
  logic [3:0] scn_a, s1_a, s2_a;

  logic       st_b = 1'b0, ng_b = 1'b0;
  logic [4:0] p1_b = '0, p2_b = '0;
  logic       busy_b, done_b, w1_b, w2_b, tie_b, i1_b, i2_b, go_b;
  logic [4:0] scn_b;
  logic [3:0] s1_b, s2_b;

  round_judge #(.NUM_CHOICES(3), .SCORE_W(4), .WIN_SCORE(2), .DEFAULT_CHOICE(0)) dut_a (
    .clk(clk), .stateReset(rst), .start(st_a), .newGame(ng_a),
    .p1Choice(p1_a), .p2Choice(p2_a), .busy(busy_a), .done(done_a),
    .scenario(scn_a), .winner1(w1_a), .winner2(w2_a), .tie(tie_a),
    .invalid1(i1_a), .invalid2(i2_a), .player1(s1_a), .player2(s2_a), .gameOver(go_a)
  );

  round_judge #(.NUM_CHOICES(5), .SCORE_W(4), .WIN_SCORE(9), .DEFAULT_CHOICE(0)) dut_b (
    .clk(clk), .stateReset(rst), .start(st_b), .newGame(ng_b),
    .p1Choice(p1_b), .p2Choice(p2_b), .busy(busy_b), .done(done_b),
    .scenario(scn_b), .winner1(w1_b), .winner2(w2_b), .tie(tie_b),
    .invalid1(i1_b), .invalid2(i2_b), .player1(s1_b), .player2(s2_b), .gameOver(go_b)
  );

  int checks = 0;
  int failures = 0;

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- round-level model ----------------
  int NN[2] = '{3, 5};
  int WW[2] = '{2, 9};
  int m_ph[2];   // cycles elapsed inside a round (0 = not in a round)
  int m_busy[2], m_done[2], m_scn[2], m_w1[2], m_w2[2], m_tie[2];
  int m_i1[2], m_i2[2], m_s1[2], m_s2[2], m_go[2];
  int q_scn[2], q_w1[2], q_w2[2], q_tie[2], q_i1[2], q_i2[2], q_s1[2], q_s2[2], q_go[2];

  function automatic void dec(input int v, input int n, output int idx, output bit ok);
    int cnt = 0;
    idx = 0;
    for (int i = 0; i < n; i++) if (v[i]) begin cnt++; idx = i; end
    ok = (cnt == 1);
    if (!ok) idx = 0;
  endfunction

  task automatic m_clear(input int k, input bit all);
    m_scn[k] = 0; m_w1[k] = 0; m_w2[k] = 0; m_tie[k] = 0;
    m_i1[k] = 0; m_i2[k] = 0; m_s1[k] = 0; m_s2[k] = 0; m_go[k] = 0;
    if (all) begin m_ph[k] = 0; m_busy[k] = 0; m_done[k] = 0; end
  endtask

  task automatic m_step(input int k, input bit st, input bit ng, input int c1, input int c2);
    int a, b, d, n, w;
    bit ok1, ok2;
    n = NN[k]; w = WW[k];
    m_done[k] = 0;
    case (m_ph[k])
      0: begin
        if (ng) m_clear(k, 1'b0);
        else if (st && !m_go[k]) begin
          // Resolve the whole round now; reveal it stage by stage below.
          dec(c1, n, a, ok1);
          dec(c2, n, b, ok2);
          d = ((b - a) % n + n) % n;
          q_i1[k] = !ok1; q_i2[k] = !ok2;
          q_tie[k] = (d == 0);
          q_w1[k] = (d >= 1 && d <= (n - 1) / 2);
          q_w2[k] = (d > (n - 1) / 2);
          q_scn[k] = a * n + b;
          q_s1[k] = (m_s1[k] + q_w1[k] > w) ? w : m_s1[k] + q_w1[k];
          q_s2[k] = (m_s2[k] + q_w2[k] > w) ? w : m_s2[k] + q_w2[k];
          q_go[k] = (q_s1[k] == w || q_s2[k] == w);
          m_busy[k] = 1; m_ph[k] = 1;
        end
      end
      1: begin m_i1[k] = q_i1[k]; m_i2[k] = q_i2[k]; m_ph[k] = 2; end
      2: begin
        m_w1[k] = q_w1[k]; m_w2[k] = q_w2[k]; m_tie[k] = q_tie[k];
        m_scn[k] = q_scn[k]; m_ph[k] = 3;
      end
      default: begin
        m_s1[k] = q_s1[k]; m_s2[k] = q_s2[k]; m_go[k] = q_go[k];
        m_done[k] = 1; m_busy[k] = 0; m_ph[k] = 0;
      end
    endcase
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_clear(0, 1'b1);
      m_clear(1, 1'b1);
    end else begin
      m_step(0, st_a, ng_a, int'(p1_a), int'(p2_a));
      m_step(1, st_b, ng_b, int'(p1_b), int'(p2_b));
    end
  end

  task automatic cmp_k(input int k, input int busy, input int done, input int scn,
                       input int w1, input int w2, input int tie, input int i1,
                       input int i2, input int s1, input int s2, input int go);
    cmp($sformatf("i%0d.busy", k), busy, m_busy[k]);
    cmp($sformatf("i%0d.done", k), done, m_done[k]);
    cmp($sformatf("i%0d.scenario", k), scn, m_scn[k]);
    cmp($sformatf("i%0d.winner1", k), w1, m_w1[k]);
    cmp($sformatf("i%0d.winner2", k), w2, m_w2[k]);
    cmp($sformatf("i%0d.tie", k), tie, m_tie[k]);
    cmp($sformatf("i%0d.invalid1", k), i1, m_i1[k]);
    cmp($sformatf("i%0d.invalid2", k), i2, m_i2[k]);
    cmp($sformatf("i%0d.player1", k), s1, m_s1[k]);
    cmp($sformatf("i%0d.player2", k), s2, m_s2[k]);
    cmp($sformatf("i%0d.gameOver", k), go, m_go[k]);
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    cmp_k(0, busy_a, done_a, scn_a, w1_a, w2_a, tie_a, i1_a, i2_a, s1_a, s2_a, go_a);
    cmp_k(1, busy_b, done_b, scn_b, w1_b, w2_b, tie_b, i1_b, i2_b, s1_b, s2_b, go_b);
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic done_k(input int k);
    return (k == 0) ? done_a : done_b;
  endfunction

  task automatic set_in(input int k, input bit st, input int c1, input int c2);
    if (k == 0) begin st_a = st; p1_a = c1[2:0]; p2_a = c2[2:0]; end
    else begin st_b = st; p1_b = c1[4:0]; p2_b = c2[4:0]; end
  endtask

  // One round; choices are swapped right after the start edge to prove they were captured.
  task automatic play(input int k, input int c1, input int c2, output int lat);
    @(negedge clk);
    set_in(k, 1'b1, c1, c2);
    @(posedge clk);
    @(negedge clk);
    set_in(k, 1'b0, c2, c1);
    lat = 0;
    while (!done_k(k) && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic new_game_a();
    @(negedge clk); ng_a = 1'b1;
    @(posedge clk);
    @(negedge clk); ng_a = 1'b0;
  endtask

  int lat, cnt;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cmp("reset.busy", busy_a, 0);
    cmp("reset.scenario", scn_a, 0);
    cmp("reset.player1", s1_a, 0);
    cmp("reset.gameOver", go_a, 0);

    // Abort a round while it sits in DECODE.
    @(negedge clk); set_in(0, 1'b1, 1, 2);
    @(posedge clk);
    @(negedge clk); set_in(0, 1'b0, 1, 2);
    cmp("decode.busy", busy_a, 1);
    #2 rst = 1'b1;
    #1 cmp("abort.busy", busy_a, 0);
    @(negedge clk); rst = 1'b0;
    cnt = 0;
    repeat (6) begin @(negedge clk); if (done_a) cnt++; end
    cmp("abort.no_done", cnt, 0);
    cmp("abort.player1", s1_a, 0);

    // N=3 rounds.
    play(0, 3'b001, 3'b010, lat);
    cmp("r1.latency", lat, 3);
    cmp("r1.winner1", w1_a, 1);
    cmp("r1.scenario", scn_a, 1);
    cmp("r1.player1", s1_a, 1);
    cmp("r1.player2", s2_a, 0);
    @(negedge clk);
    cmp("r1.done_clears", done_a, 0);

    play(0, 3'b100, 3'b100, lat);
    cmp("r2.tie", tie_a, 1);
    cmp("r2.scenario", scn_a, 8);
    cmp("r2.player1", s1_a, 1);

    play(0, 3'b011, 3'b100, lat);
    cmp("r3.invalid1", i1_a, 1);
    cmp("r3.invalid2", i2_a, 0);
    cmp("r3.winner2", w2_a, 1);
    cmp("r3.scenario", scn_a, 2);
    cmp("r3.player2", s2_a, 1);

    // N=5 rounds.
    play(1, 5'b00001, 5'b01000, lat);
    cmp("n5a.latency", lat, 3);
    cmp("n5a.winner2", w2_b, 1);
    cmp("n5a.scenario", scn_b, 3);
    play(1, 5'b10000, 5'b00010, lat);
    cmp("n5b.winner1", w1_b, 1);
    cmp("n5b.scenario", scn_b, 21);
    play(1, 5'b00000, 5'b11000, lat);
    cmp("n5c.invalid2", i2_b, 1);
    cmp("n5c.tie", tie_b, 1);
    cmp("n5c.scenario", scn_b, 0);

    // Play to the win target of 2.
    new_game_a();
    cmp("ng.player2", s2_a, 0);
    play(0, 3'b001, 3'b010, lat);
    cmp("go1.gameOver", go_a, 0);
    play(0, 3'b001, 3'b010, lat);
    cmp("go2.player1", s1_a, 2);
    cmp("go2.gameOver", go_a, 1);
    @(negedge clk); st_a = 1'b1;
    @(negedge clk); st_a = 1'b0;
    cnt = 0;
    repeat (5) begin @(negedge clk); if (busy_a) cnt++; end
    cmp("go.start_ignored", cnt, 0);
    new_game_a();
    cmp("go.cleared_player1", s1_a, 0);
    cmp("go.cleared_gameOver", go_a, 0);

    // start and newGame together: newGame wins.
    play(0, 3'b001, 3'b010, lat);
    @(negedge clk); st_a = 1'b1; ng_a = 1'b1;
    @(posedge clk);
    @(negedge clk); st_a = 1'b0; ng_a = 1'b0;
    cmp("both.player1", s1_a, 0);
    cmp("both.busy", busy_a, 0);

    // start pulsed while the round is in JUDGE; chicken beats cat.
    @(negedge clk); set_in(0, 1'b1, 3'b100, 3'b001);
    @(posedge clk);
    @(negedge clk); set_in(0, 1'b0, 3'b100, 3'b001);
    @(posedge clk);
    @(negedge clk); st_a = 1'b1;
    @(posedge clk);
    @(negedge clk); st_a = 1'b0;
    cnt = 0;
    repeat (10) begin @(negedge clk); if (done_a) cnt++; end
    cmp("judge_start.done_count", cnt, 1);
    cmp("judge_start.winner1", w1_a, 1);
    cmp("judge_start.scenario", scn_a, 6);
    cmp("judge_start.player1", s1_a, 1);

    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
